fec_conv_encoder: RTL and testbench
===================================

# fec_conv_encoder

Rate-1/2, constraint-length-7 convolutional encoder stage that drains message words from the encoder ping-pong buffer and produces a 2-bit coded symbol stream. It sits directly downstream of the circular buffer in the FEC encoder path: it issues read requests while the buffer is non-empty, serializes each word MSB first, and encodes each bit. After every FRAME_WORDS words it appends 6 zero tail bits, so each frame terminates the trellis in state 0.

## Interface
- DATA_WIDTH, 8: width of one message word read from the buffer (message_data_t width).
- FRAME_WORDS, 4: message words per encoded frame; must be ≥1.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- buf_empty  in  1  buffer has no readable word.
- buf_rd_en  out  1  read request to buffer; one word per asserted cycle.
- buf_rd_valid  in  1  buf_data valid; returns exactly 1 cycle after buf_rd_en.
- buf_data  in  DATA_WIDTH  word returned by buffer.
- sym_out  out  2  coded symbol {c0,c1}.
- sym_valid  out  1  sym_out valid.
- sym_ready  in  1  downstream accepts symbol when sym_valid && sym_ready.
- sym_last  out  1  qualifies the final tail symbol of a frame.
- busy  out  1  high in any state other than IDLE.
- err_unexp_valid  out  1  sticky: buf_rd_valid seen outside WAIT; cleared only by rst.

## Operation
- Code: K=7, generators G0=171 octal (1111001b), G1=133 octal (1011011b). The window is w[6:0] = {u, s1..s6}, where u is the current bit, s1 is the most recent past bit, and w[6]=u. c0 = XOR-reduce(w & G0), c1 = XOR-reduce(w & G1).
- Encoder state sr[5:0] = {s1..s6}. It updates only on a symbol handshake: sr <= {u, sr[5:1]}. It is cleared at frame start and on rst.
- States: IDLE, REQ, WAIT, SHIFT, TAIL.
  - IDLE: buf_rd_en = !buf_empty (combinational). If !buf_empty: clear sr and word_cnt, go WAIT.
  - REQ: mid-frame fetch. buf_rd_en = !buf_empty. Go WAIT when !buf_empty; otherwise stay, holding sr and word_cnt.
  - WAIT: on buf_rd_valid, load buf_data into the shift register, set bit_cnt=0, go SHIFT.
  - SHIFT: u = shift-register MSB; sym_valid=1. On handshake, shift left and bit_cnt++.
    - After bit DATA_WIDTH-1: if word_cnt == FRAME_WORDS-1 go TAIL with tail_cnt=0; otherwise word_cnt++ and go REQ.
  - TAIL: u=0; sym_valid=1. On handshake, tail_cnt++. sym_last=1 when tail_cnt==5; on that handshake go IDLE.
- Symbols per frame = FRAME_WORDS*DATA_WIDTH + 6. After the final tail symbol sr is all zeros by construction.
- Only one buffer read is outstanding; buf_rd_en is never asserted outside IDLE/REQ.
- buf_rd_valid in any state other than WAIT is ignored (data discarded) and sets err_unexp_valid.
- If WAIT does not see buf_rd_valid, the block stays in WAIT indefinitely. The buffer contract guarantees the 1-cycle response.

## Timing
- Reset values: buf_rd_en=0, sym_out=2'b00, sym_valid=0, sym_last=0, busy=0, err_unexp_valid=0. State returns to IDLE; sr, word_cnt, bit_cnt and tail_cnt are all 0.
- Request/response sequence: buf_rd_en at cycle T, buf_rd_valid at T+1, first symbol of that word valid at T+2.
- Best-case frame length: FRAME_WORDS*(DATA_WIDTH+2) + 6 cycles from first buf_rd_en to the last symbol handshake. Each word costs a 2-cycle REQ/WAIT bubble.
- Backpressure: while sym_valid && !sym_ready, sym_out and sym_last hold stable and no state advances.
- sym_out, sym_valid and sym_last are combinational from registered state, with no dependence on sym_ready.
- buf_empty high in REQ stalls the frame with sym_valid=0. Encoding resumes with unchanged sr once a word arrives. There is no timeout and no premature tail.
- rst asserted mid-frame: the partial frame is abandoned with no tail emitted. Outputs take reset values in the cycle after rst is sampled.
- Back-to-back frames: from IDLE with !buf_empty, buf_rd_en asserts in the same cycle the previous frame's final handshake moved the state to IDLE (next cycle), so there is one IDLE cycle between frames.

## Test plan
- Impulse, DATA_WIDTH=8, FRAME_WORDS=1, word 0x80, sym_ready=1 -> 14 symbols: 11,10,11,11,00,01,11, then seven 00. sym_last is on the 14th symbol and busy drops after it.
- All-zero frame, FRAME_WORDS=4, words 0x00 -> 38 symbols all 00. There are 4 buf_rd_en pulses, each followed 2 cycles later by a symbol.
- Continuity: words 0x01 then 0x00 (FRAME_WORDS=2) -> symbols 8..14 (1-based) = 11,10,11,11,00,01,11, with sr carried across the REQ gap. A stall with buf_empty=1 for 5 cycles before word 2 yields the identical symbol sequence.
- Backpressure: random sym_ready (~50%) on random data -> symbol sequence matches a reference model, and sym_out is stable during every stall cycle.
- Reset mid-frame: rst at symbol 5 of frame 1, then a new frame -> all outputs are 0 the next cycle. The new frame starts from sr=0 and matches the reference model.
- Spurious buf_rd_valid pulse during SHIFT -> err_unexp_valid=1 and stays 1, the symbol stream is unaffected, and the flag clears only on rst.

Source files
------------

// File: rtl/fec_conv_encoder_if.sv
// Buffer read channel and coded symbol stream of the convolutional encoder.
// The master side is the encoder; the slave side is the buffer plus downstream sink.
interface fec_conv_encoder_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  buf_empty;
    logic                  buf_rd_en;
    logic                  buf_rd_valid;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [1:0]            sym_out;
    logic                  sym_valid;
    logic                  sym_ready;
    logic                  sym_last;

    modport master (
        input  buf_empty,
        input  buf_rd_valid,
        input  buf_data,
        input  sym_ready,
        output buf_rd_en,
        output sym_out,
        output sym_valid,
        output sym_last
    );

    modport slave (
        output buf_empty,
        output buf_rd_valid,
        output buf_data,
        output sym_ready,
        input  buf_rd_en,
        input  sym_out,
        input  sym_valid,
        input  sym_last
    );
endinterface

// File: rtl/fec_conv_encoder.sv
// Rate-1/2 K=7 convolutional encoder (G0=171o, G1=133o) draining message words
// MSB first from the buffer and closing each frame with 6 zero tail bits.
module fec_conv_encoder #(
    parameter int DATA_WIDTH  = 8,
    parameter int FRAME_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fec_conv_encoder_if.master   bus,
    output logic                 busy,
    output logic                 err_unexp_valid
);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int WORD_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(FRAME_WORDS - 1);
    localparam logic [6:0] G0 = 7'b1111001;
    localparam logic [6:0] G1 = 7'b1011011;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, SHIFT, TAIL} state_t;

    state_t                state, state_nxt;
    logic [5:0]            sr;
    logic [DATA_WIDTH-1:0] word_sh;
    logic [BIT_W-1:0]      bit_cnt;
    logic [WORD_W-1:0]     word_cnt;
    logic [2:0]            tail_cnt;
    logic                  u;
    logic                  sym_vld;
    logic                  sym_hs;
    logic                  word_done;
    logic                  frame_done;
    logic                  tail_done;

    // Window is {u, s1..s6} with the current bit in the MSB.
    function automatic logic [1:0] conv_sym(input logic [6:0] w);
        return {^(w & G0), ^(w & G1)};
    endfunction

    assign u          = (state == SHIFT) ? word_sh[DATA_WIDTH-1] : 1'b0;
    assign sym_vld    = (state == SHIFT) || (state == TAIL);
    assign sym_hs     = sym_vld && bus.sym_ready;
    assign word_done  = (bit_cnt == BIT_LAST);
    assign frame_done = (word_cnt == WORD_LAST);
    assign tail_done  = (tail_cnt == 3'd5);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!bus.buf_empty) state_nxt = WAIT;
            REQ:     if (!bus.buf_empty) state_nxt = WAIT;
            WAIT:    if (bus.buf_rd_valid) state_nxt = SHIFT;
            SHIFT:   if (sym_hs && word_done) state_nxt = frame_done ? TAIL : REQ;
            TAIL:    if (sym_hs && tail_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Encoder memory, word shifter and counters advance only on handshakes or fetches.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr              <= '0;
            word_sh         <= '0;
            bit_cnt         <= '0;
            word_cnt        <= '0;
            tail_cnt        <= '0;
            err_unexp_valid <= 1'b0;
        end else begin
            if (bus.buf_rd_valid && (state != WAIT)) begin
                err_unexp_valid <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (!bus.buf_empty) begin
                        sr       <= '0;
                        word_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (bus.buf_rd_valid) begin
                        word_sh <= bus.buf_data;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (sym_hs) begin
                        sr      <= {u, sr[5:1]};
                        word_sh <= word_sh << 1;
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (word_done) begin
                            if (frame_done) begin
                                tail_cnt <= '0;
                            end else begin
                                word_cnt <= word_cnt + WORD_W'(1);
                            end
                        end
                    end
                end
                TAIL: begin
                    if (sym_hs) begin
                        sr       <= {u, sr[5:1]};
                        tail_cnt <= tail_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read request is suppressed while rst is held so no word is popped into a reset.
    always_comb begin
        bus.buf_rd_en = !rst && ((state == IDLE) || (state == REQ)) && !bus.buf_empty;
        bus.sym_valid = sym_vld;
        bus.sym_out   = sym_vld ? conv_sym({u, sr}) : 2'b00;
        bus.sym_last  = (state == TAIL) && tail_done;
        busy          = (state != IDLE);
    end
endmodule

// File: tb/tb_fec_conv_encoder.sv
// Scoreboard bench for fec_conv_encoder: buffer responder, random backpressure,
// and a convolution-sum reference model feeding an expected-symbol queue.
module tb_fec_conv_encoder;
    localparam int DW = 8;
    localparam int FW = 2;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic err;

    fec_conv_encoder_if #(.DATA_WIDTH(DW)) bus();

    fec_conv_encoder #(.DATA_WIDTH(DW), .FRAME_WORDS(FW)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .busy           (busy),
        .err_unexp_valid(err)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] buf_q[$];
    logic [2:0]    exp_q[$];
    logic [DW-1:0] frame_w[$];
    bit            rst_req = 1'b1;
    bit            stall = 1'b0;
    bit            ready_rand = 1'b0;
    bit            spur_req = 1'b0;
    bit            pend_v = 1'b0;
    logic [DW-1:0] pend_d;
    int            rd_cnt = 0;
    int            hs_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each coded bit is the GF(2) convolution of the frame bit stream with
    // the generator taps; tap k of the window multiplies the bit k positions back.
    task automatic push_frame();
        bit         b[$];
        logic [6:0] g0 = 7'o171;
        logic [6:0] g1 = 7'o133;
        bit         c0;
        bit         c1;
        logic [DW-1:0] w;
        for (int i = 0; i < frame_w.size(); i++) begin
            w = frame_w[i];
            buf_q.push_back(w);
            for (int j = DW - 1; j >= 0; j--) b.push_back(w[j]);
        end
        repeat (6) b.push_back(1'b0);
        for (int n = 0; n < b.size(); n++) begin
            c0 = 1'b0;
            c1 = 1'b0;
            for (int k = 0; k < 7; k++) begin
                if (n >= k) begin
                    c0 ^= g0[6-k] & b[n-k];
                    c1 ^= g1[6-k] & b[n-k];
                end
            end
            exp_q.push_back({(n == b.size() - 1), c0, c1});
        end
        frame_w.delete();
    endtask

    task automatic rand_frame();
        frame_w.delete();
        repeat (FW) frame_w.push_back(DW'($urandom));
        push_frame();
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && t < 3000) begin
            @(negedge clk);
            #2;
            t++;
        end
        check({name, "_complete"}, 32'((exp_q.size() == 0) && (busy === 1'b0)), 32'd1);
    endtask

    // Buffer responder and sink: inputs change 1 after the falling edge.
    initial begin
        rst              = 1'b1;
        bus.sym_ready    = 1'b1;
        bus.buf_rd_valid = 1'b0;
        bus.buf_data     = '0;
        bus.buf_empty    = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            rst           = rst_req;
            bus.sym_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pend_v) begin
                bus.buf_rd_valid = 1'b1;
                bus.buf_data     = pend_d;
                pend_v           = 1'b0;
            end else if (spur_req) begin
                bus.buf_rd_valid = 1'b1;
                bus.buf_data     = DW'($urandom);
                spur_req         = 1'b0;
            end else begin
                bus.buf_rd_valid = 1'b0;
            end
            bus.buf_empty = stall || (buf_q.size() == 0);
            #1;
            if (bus.buf_rd_en && buf_q.size() != 0) begin
                pend_d = buf_q.pop_front();
                pend_v = 1'b1;
                rd_cnt++;
            end
        end
    end

    // Monitor: compares every symbol that will be accepted at the next rising edge.
    initial begin
        bit         prev_stall = 1'b0;
        logic [2:0] prev_obs = '0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_held", 32'(bus.sym_valid), 32'd1);
                    check("stall_symbol_held", 32'({bus.sym_last, bus.sym_out}), 32'(prev_obs));
                end
                if (bus.sym_valid && bus.sym_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_symbol: got %0h, expected none (t=%0t)",
                                 {bus.sym_last, bus.sym_out}, $time);
                    end else begin
                        check($sformatf("symbol_%0d", hs_cnt),
                              32'({bus.sym_last, bus.sym_out}), 32'(exp_q.pop_front()));
                    end
                    hs_cnt++;
                end
                prev_stall = bus.sym_valid && !bus.sym_ready;
                prev_obs   = {bus.sym_last, bus.sym_out};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int r0;
        int h0;

        repeat (3) @(negedge clk);
        #2;
        check("rst_buf_rd_en", 32'(bus.buf_rd_en), 32'd0);
        check("rst_sym_out", 32'(bus.sym_out), 32'd0);
        check("rst_sym_valid", 32'(bus.sym_valid), 32'd0);
        check("rst_sym_last", 32'(bus.sym_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_req = 1'b0;

        frame_w = '{8'h80, 8'h00};
        push_frame();
        wait_idle("impulse");

        r0 = rd_cnt;
        frame_w = '{8'h00, 8'h00};
        push_frame();
        wait_idle("zeros");
        check("zeros_rd_pulses", 32'(rd_cnt - r0), 32'(FW));

        frame_w = '{8'h01, 8'h00};
        push_frame();
        wait_idle("continuity");

        r0 = rd_cnt;
        frame_w = '{8'h01, 8'h00};
        push_frame();
        t = 0;
        while (rd_cnt == r0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        stall = 1'b1;
        repeat (14) @(negedge clk);
        #2;
        check("stalled_in_req", 32'({bus.sym_valid, busy, bus.buf_rd_en}), 32'b010);
        stall = 1'b0;
        wait_idle("continuity_stall");

        ready_rand = 1'b1;
        repeat (6) rand_frame();
        wait_idle("backpressure");
        ready_rand = 1'b0;

        rand_frame();
        h0 = hs_cnt;
        t = 0;
        while (hs_cnt - h0 < 5 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("mid_frame_reached", 32'(hs_cnt - h0), 32'd5);
        rst_req = 1'b1;
        buf_q.delete();
        exp_q.delete();
        pend_v = 1'b0;
        @(negedge clk);
        #2;
        check("midrst_buf_rd_en", 32'(bus.buf_rd_en), 32'd0);
        check("midrst_sym_out", 32'(bus.sym_out), 32'd0);
        check("midrst_sym_valid", 32'(bus.sym_valid), 32'd0);
        check("midrst_sym_last", 32'(bus.sym_last), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst_req = 1'b0;
        @(negedge clk);
        rand_frame();
        wait_idle("after_reset");

        rand_frame();
        t = 0;
        while (bus.sym_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            #2;
            t++;
        end
        spur_req = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("err_set", 32'(err), 32'd1);
        wait_idle("spurious");
        check("err_sticky", 32'(err), 32'd1);
        rand_frame();
        wait_idle("spurious_next");
        check("err_still_sticky", 32'(err), 32'd1);
        rst_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        check("err_cleared", 32'(err), 32'd0);
        rst_req = 1'b0;
        @(negedge clk);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
